// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencing block:
// opcode encoding, controller state encoding and default latencies.
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MSUB  = 4'd10
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;
    localparam int CNT_W_DEF    = 4;

endpackage

// File: rtl/mdu_ctrl_if.sv
// EX-stage <-> MDU controller bundle: op request, flush, stall feedback
// and the architectural HI/LO view.
interface mdu_ctrl_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        busy;
    logic        stall_req;
    logic [31:0] hilo_rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_val, rt_val, flush,
        input  busy, stall_req, hilo_rdata, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, flush,
        output busy, stall_req, hilo_rdata, hi, lo
    );
endinterface

// File: rtl/mdu_arith.sv
// Combinational 64-bit result generator for the MDU; the controller
// latches its outputs at accept time and releases them after the latency.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div0
);

    logic signed [63:0] rs_w;
    logic signed [63:0] rt_w;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [63:0] acc;
    logic signed [31:0] rt_sdiv;
    logic        [31:0] rt_udiv;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;
    logic               ovf;

    always_comb begin
        rs_w   = {{32{rs[31]}}, rs};
        rt_w   = {{32{rt[31]}}, rt};
        prod_s = rs_w * rt_w;
        prod_u = {32'd0, rs} * {32'd0, rt};
        acc    = {hi, lo};

        // Dividing by one in the overflow case yields exactly the wrapped
        // quotient 0x80000000 with zero remainder, and avoids a zero divisor.
        ovf     = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);
        rt_sdiv = (rt == 32'd0 || ovf) ? 32'sd1 : $signed(rt);
        rt_udiv = (rt == 32'd0) ? 32'd1 : rt;
        quo_s   = $signed(rs) / rt_sdiv;
        rem_s   = $signed(rs) % rt_sdiv;
        quo_u   = rs / rt_udiv;
        rem_u   = rs % rt_udiv;

        res_hi = '0;
        res_lo = '0;
        div0   = 1'b0;
        case (op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV: begin
                res_hi = rem_s;
                res_lo = quo_s;
                div0   = (rt == 32'd0);
            end
            OP_DIVU: begin
                res_hi = rem_u;
                res_lo = quo_u;
                div0   = (rt == 32'd0);
            end
            OP_MADD:  {res_hi, res_lo} = acc + prod_s;
            OP_MSUB:  {res_hi, res_lo} = acc - prod_s;
            default: begin
                res_hi = '0;
                res_lo = '0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencing controller: accepts ops, models latency with a busy
// counter, stalls the pipe and commits HI/LO. Macro MDU_MADD_EN enables MADD/MSUB.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  bus
);

    mdu_state_e       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [31:0]      pend_hi_reg, pend_hi_next;
    logic [31:0]      pend_lo_reg, pend_lo_next;
    logic             pend_div0_reg, pend_div0_next;
    logic [31:0]      hi_reg, hi_next;
    logic [31:0]      lo_reg, lo_next;

    logic             busy;
    logic             stall;
    logic             accept;
    logic             is_long;
    logic [CNT_W-1:0] lat_init;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             res_div0;

    mdu_arith u_arith (
        .op     (bus.op),
        .rs     (bus.rs_val),
        .rt     (bus.rt_val),
        .hi     (hi_reg),
        .lo     (lo_reg),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .div0   (res_div0)
    );

    assign busy   = (state_reg == ST_BUSY);
    // Held through the final busy cycle: a waiting op is only taken once IDLE.
    assign stall  = bus.start && busy;
    assign accept = bus.start && !stall && !bus.flush;

    always_comb begin
        is_long  = 1'b0;
        lat_init = '0;
        case (bus.op)
            OP_MULT, OP_MULTU: begin
                is_long  = 1'b1;
                lat_init = CNT_W'(MULT_LAT - 1);
            end
            OP_DIV, OP_DIVU: begin
                is_long  = 1'b1;
                lat_init = CNT_W'(DIV_LAT - 1);
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MSUB: begin
                is_long  = 1'b1;
                lat_init = CNT_W'(MULT_LAT - 1);
            end
`endif
            default: begin
                is_long  = 1'b0;
                lat_init = '0;
            end
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        pend_hi_next   = pend_hi_reg;
        pend_lo_next   = pend_lo_reg;
        pend_div0_next = pend_div0_reg;
        hi_next        = hi_reg;
        lo_next        = lo_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (is_long) begin
                        state_next     = ST_BUSY;
                        cnt_next       = lat_init;
                        pend_hi_next   = res_hi;
                        pend_lo_next   = res_lo;
                        pend_div0_next = res_div0;
                    end else if (bus.op == OP_MTHI) begin
                        hi_next = bus.rs_val;
                    end else if (bus.op == OP_MTLO) begin
                        lo_next = bus.rs_val;
                    end
                end
            end
            ST_BUSY: begin
                if (bus.flush) begin
                    state_next     = ST_IDLE;
                    pend_hi_next   = '0;
                    pend_lo_next   = '0;
                    pend_div0_next = 1'b0;
                end else if (cnt_reg == '0) begin
                    state_next = ST_IDLE;
                    // A zero divisor still costs the full latency but leaves HI/LO alone.
                    if (!pend_div0_reg) begin
                        hi_next = pend_hi_reg;
                        lo_next = pend_lo_reg;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            pend_hi_reg   <= '0;
            pend_lo_reg   <= '0;
            pend_div0_reg <= 1'b0;
            hi_reg        <= '0;
            lo_reg        <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            pend_hi_reg   <= pend_hi_next;
            pend_lo_reg   <= pend_lo_next;
            pend_div0_reg <= pend_div0_next;
            hi_reg        <= hi_next;
            lo_reg        <= lo_next;
        end
    end

    always_comb begin
        bus.hilo_rdata = 32'd0;
        if (bus.op == OP_MFHI) begin
            bus.hilo_rdata = hi_reg;
        end else if (bus.op == OP_MFLO) begin
            bus.hilo_rdata = lo_reg;
        end
    end

    assign bus.busy      = busy;
    assign bus.stall_req = stall;
    assign bus.hi        = hi_reg;
    assign bus.lo        = lo_reg;

endmodule
